// File: rtl/afifo_burst_reader.sv
// Read-domain burst consumer: pops a requested number of words from an async FIFO
// into a 2-entry queue and streams them out as valid/ready. Optional: AFIFO_RD_STALL_STATS_EN.
module afifo_burst_reader #(
  parameter int DSIZE = 8,
  parameter int LSIZE = 8
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic             rd_empty,
  input  logic [DSIZE-1:0] rd_data,
  output logic             rd_inc,
  input  logic             start,
  input  logic [LSIZE-1:0] burst_len,
  input  logic             abort,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LSIZE-1:0] rd_count
`ifdef AFIFO_RD_STALL_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t           state;
  logic [LSIZE-1:0] remaining;
  logic [1:0]       occ;
  logic [DSIZE-1:0] q1;
  logic             pop;

  assign pop       = out_valid & out_ready;
  assign out_valid = (occ != 2'd0);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Pop only when there is both a word in the FIFO and room in the queue.
  assign rd_inc = (state == S_READ) & ~rd_empty & (remaining != '0) & ~abort &
                  (occ != 2'd2);

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      rd_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rd_count <= '0;
            if (burst_len != '0) begin
              remaining <= burst_len;
              state     <= S_READ;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_READ: begin
          if (abort) begin
            remaining <= '0;
            state     <= S_DRAIN;
          end else if (rd_inc) begin
            remaining <= remaining - 1'b1;
            rd_count  <= rd_count + 1'b1;
            if (remaining == LSIZE'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (occ == 2'd0 && !rd_inc) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // out_data is the queue head; q1 holds the second entry when occ==2.
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      occ      <= 2'd0;
      out_data <= '0;
      q1       <= '0;
    end else begin
      case ({rd_inc, pop})
        2'b10: begin
          if (occ == 2'd0) out_data <= rd_data;
          else             q1       <= rd_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          out_data <= q1;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            out_data <= q1;
            q1       <= rd_data;
          end else begin
            out_data <= rd_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AFIFO_RD_STALL_STATS_EN
  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      stall_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == S_READ && remaining != '0 && (rd_empty || occ == 2'd2) &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/afifo_burst_reader.md
Name: afifo_burst_reader

Overview:
- Read-side consumer for the async FIFO; runs entirely in the read clock domain.
- On a start command, pops exactly burst_len words through the FIFO read port (rd_inc/rd_empty/rd_data).
- Buffers popped words in a 2-entry output queue and presents them downstream as a valid/ready stream.
- Counterpart to the write-side producer logic; tolerates FIFO underflow and downstream backpressure.

Parameters:
- DSIZE, 8, data word width; matches the FIFO DSIZE.
- LSIZE, 8, width of the burst length and word counters.

Ports:
- rd_clk  input  1  read-domain clock.
- rd_rst  input  1  asynchronous, active-low reset.
- rd_empty  input  1  FIFO empty flag (read domain).
- rd_data  input  DSIZE  FIFO head word; valid combinationally whenever rd_empty=0.
- rd_inc  output  1  FIFO pop strobe; the head word is consumed at the rising edge where rd_inc=1.
- start  input  1  one-cycle burst request; sampled in IDLE only.
- burst_len  input  LSIZE  words to pop; sampled with start.
- abort  input  1  stop popping early; acted on in READ only.
- out_data  output  DSIZE  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse at burst completion.
- rd_count  output  LSIZE  words popped in the current/last burst.

Behaviour:
- Reset (rd_rst=0, async): state IDLE, queue emptied, remaining=0.
  - Outputs: rd_inc=0, out_valid=0, out_data=0, busy=0, done=0, rd_count=0.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 with burst_len!=0 -> READ; remaining<=burst_len, rd_count<=0.
  - IDLE: start=1 with burst_len==0 -> DONE; rd_count<=0.
  - READ: the cycle rd_inc pops the last word (remaining 1->0) -> DRAIN.
  - READ: abort=1 -> DRAIN; rd_inc is forced 0 in that cycle; remaining is discarded.
  - DRAIN: queue occupancy 0 and no push this cycle -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start is ignored when state is not IDLE; abort is ignored outside READ.
- rd_inc is combinational:
  - rd_inc = (state==READ) & ~rd_empty & (remaining!=0) & ~abort & (occupancy<2).
  - Never asserted while rd_empty=0 is not true (no underflow pop).
- Each cycle with rd_inc=1:
  - rd_data is written into the queue at that edge.
  - remaining decrements by 1; rd_count increments by 1.
- Latency: a word popped at edge N appears on out_data with out_valid=1 after edge N (from cycle N+1) when the queue was empty.
- Queue: 2-entry FIFO ordering.
  - Push and pop in the same cycle leaves occupancy unchanged.
  - Sustains 1 word/clk with out_ready held high and rd_empty low.
- Stream rules:
  - out_valid=1 iff occupancy>0; out_data is the queue head.
  - While out_valid & ~out_ready, out_data and out_valid hold stable.
  - Transfer occurs on an edge with out_valid & out_ready.
- FIFO going empty mid-burst: rd_inc stays 0, FSM stays in READ, no timeout.
- Reset mid-burst: all state is cleared immediately; FIFO words not yet popped remain in the FIFO.
- rd_count is held after DONE until the next accepted start.

Optional Feature:
- Macro: AFIFO_RD_STALL_STATS_EN.
- With the macro: adds output stall_cnt [15:0]. Counts cycles in READ where remaining!=0 and either rd_empty=1 or occupancy==2. Cleared on accepted start and on reset; saturates at 16'hFFFF.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- FIFO preloaded with 0x11..0x14, burst_len=4, out_ready=1 -> rd_inc high 4 consecutive cycles; out_data 0x11,0x12,0x13,0x14 on consecutive cycles; done pulse 1 cycle; rd_count=4.
- burst_len=3, out_ready=0 -> exactly 2 pops then rd_inc=0 (queue full); out_data holds 0x11; raising out_ready releases the third pop; order preserved.
- FIFO empty at start, burst_len=2; push 0xA5 after 5 cycles, 0x5A after 3 more -> rd_inc only while rd_empty=0; outputs 0xA5, 0x5A; done follows; stall_cnt=8 with AFIFO_RD_STALL_STATS_EN.
- burst_len=6, abort asserted after 2 pops -> no further rd_inc; 2 words delivered; done pulses; rd_count=2; 4 words remain in the FIFO.
- start with burst_len=0 -> DONE next cycle; rd_inc never asserted; rd_count=0. A start while busy -> ignored, rd_count unaffected.
- rd_rst low mid-burst with 1 word queued -> out_valid=0, busy=0, rd_inc=0 immediately; after release, a new burst reads the next unpopped FIFO word.
